dcache_mmio_responder: RTL

Responder end of the MEM-stage data-access handshake: accepts addr/w_data with r_valid/w_valid from the pipeline and returns r_ready/w_ready/r_data. Cacheable addresses are served by a direct-mapped, write-back, write-allocate data cache backed by a word-serial memory port. The MMIO window bypasses the cache and drives the IOU byte-address bus. The pipeline derives cache_stall as "valid and not ready".

---
 rtl/dcache_pkg.sv | 47 ++++
 rtl/dcache_mmio_responder_if.sv | 49 ++++
 rtl/dcache_line_store.sv | 75 +++++++
 rtl/dcache_mmio_responder.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dcache_pkg
// Purpose  : Shared types, default geometry and address-field helpers for the
//            MEM-stage data cache / MMIO responder.
// Contents : state_t      - responder state encoding
//            DEF_*        - default geometry and MMIO window tag
//            OFF_W/IDX_W/TAG_W - field widths for the default geometry
//            addr_offset/addr_index/addr_tag - field extraction helpers
// Revision : 1.0 - initial release
// ============================================================================
package dcache_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WBACK = 3'd1,
        FILL  = 3'd2,
        DONE  = 3'd3,
        IO    = 3'd4
    } state_t;

    localparam int          DEF_SETS       = 64;
    localparam int          DEF_LINE_WORDS = 4;
    localparam logic [23:0] DEF_MMIO_TAG   = 24'h00007F;

    localparam int OFF_W = $clog2(DEF_LINE_WORDS);
    localparam int IDX_W = $clog2(DEF_SETS);
    localparam int TAG_W = 32 - IDX_W - OFF_W - 2;

    // Helpers take the field widths explicitly so a module with its own
    // geometry can reuse them; callers size-cast the 32-bit result.
    function automatic logic [31:0] addr_offset(input logic [31:0] a, input int off_w);
        return (a >> 2) & ((32'd1 << off_w) - 32'd1);
    endfunction

    function automatic logic [31:0] addr_index(input logic [31:0] a, input int off_w,
                                               input int idx_w);
        return (a >> (off_w + 2)) & ((32'd1 << idx_w) - 32'd1);
    endfunction

    function automatic logic [31:0] addr_tag(input logic [31:0] a, input int off_w,
                                             input int idx_w);
        return a >> (off_w + idx_w + 2);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dcache_mmio_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : dcache_mmio_responder_if
// Purpose  : Bundles the pipeline handshake, backing-memory port and IOU bus
//            of the data-cache responder.
// Modports : slave  - the responder (dcache_mmio_responder)
//            master - the surrounding pipeline / memory / IOU environment
// Revision : 1.0 - initial release
// ============================================================================
interface dcache_mmio_responder_if;

    // Pipeline handshake
    logic [31:0] addr;
    logic [31:0] w_data;
    logic        r_valid;
    logic        w_valid;
    logic        r_ready;
    logic        w_ready;
    logic [31:0] r_data;

    // Word-serial backing memory
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    // IOU byte-address bus
    logic [7:0]  io_addr;
    logic [31:0] io_dout;
    logic [31:0] io_din;
    logic        io_we;
    logic        io_rd;

    modport slave (
        input  addr, w_data, r_valid, w_valid, mem_rdata, mem_ack, io_din,
        output r_ready, w_ready, r_data, mem_req, mem_we, mem_addr, mem_wdata,
               io_addr, io_dout, io_we, io_rd
    );

    modport master (
        output addr, w_data, r_valid, w_valid, mem_rdata, mem_ack, io_din,
        input  r_ready, w_ready, r_data, mem_req, mem_we, mem_addr, mem_wdata,
               io_addr, io_dout, io_we, io_rd
    );

endinterface
`default_nettype wire

// File: rtl/dcache_line_store.sv
`default_nettype none
// ============================================================================
// Module   : dcache_line_store
// Purpose  : Tag/valid/dirty arrays and word data array of a direct-mapped
//            cache. One combinational read port, one write port.
// Ports    : clk, rstn          - clock, synchronous active-low reset
//            index              - line index shared by read and write
//            rd_offset          - word select for the read port
//            rd_word/rd_tag/rd_valid/rd_dirty - read port results
//            word_we/wr_offset/wr_word - word write
//            line_fill/wr_tag   - mark line valid+clean with a new tag
//            dirty_set          - mark line dirty
// Revision : 1.0 - initial release
// ============================================================================
module dcache_line_store #(
    parameter int OFFSET_BITS = dcache_pkg::OFF_W,
    parameter int INDEX_BITS  = dcache_pkg::IDX_W,
    parameter int TAG_BITS    = dcache_pkg::TAG_W
) (
    input  wire logic                   clk,
    input  wire logic                   rstn,
    input  wire logic [INDEX_BITS-1:0]  index,
    input  wire logic [OFFSET_BITS-1:0] rd_offset,
    output logic      [31:0]            rd_word,
    output logic      [TAG_BITS-1:0]    rd_tag,
    output logic                        rd_valid,
    output logic                        rd_dirty,
    input  wire logic                   word_we,
    input  wire logic [OFFSET_BITS-1:0] wr_offset,
    input  wire logic [31:0]            wr_word,
    input  wire logic                   line_fill,
    input  wire logic [TAG_BITS-1:0]    wr_tag,
    input  wire logic                   dirty_set
);

    localparam int c_LINES = 2 ** INDEX_BITS;
    localparam int c_WORDS = 2 ** (INDEX_BITS + OFFSET_BITS);

    logic [31:0]         r_words [c_WORDS];
    logic [TAG_BITS-1:0] r_tags  [c_LINES];
    logic [c_LINES-1:0]  r_valid;
    logic [c_LINES-1:0]  r_dirty;

    assign rd_word  = r_words[{index, rd_offset}];
    assign rd_tag   = r_tags[index];
    assign rd_valid = r_valid[index];
    assign rd_dirty = r_dirty[index];

    // Data and tags are left uninitialised; only the state bits reset.
    always_ff @(posedge clk) begin
        if (word_we) begin
            r_words[{index, wr_offset}] <= wr_word;
        end
        if (line_fill) begin
            r_tags[index] <= wr_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else begin
            if (line_fill) begin
                r_valid[index] <= 1'b1;
                r_dirty[index] <= 1'b0;
            end
            if (dirty_set) begin
                r_dirty[index] <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/dcache_mmio_responder.sv
`default_nettype none
// ============================================================================
// Module   : dcache_mmio_responder
// Purpose  : MEM-stage data-access responder. Cacheable addresses go through a
//            direct-mapped write-back write-allocate cache refilled over a
//            word-serial memory port; the MMIO window bypasses to the IOU bus.
// Ports    : clk, rstn - clock, synchronous active-low reset
//            bus       - dcache_mmio_responder_if.slave (pipeline handshake,
//                        backing-memory port, IOU bus)
// Revision : 1.0 - initial release
// ============================================================================
module dcache_mmio_responder
    import dcache_pkg::*;
#(
    parameter int          SETS       = DEF_SETS,
    parameter int          LINE_WORDS = DEF_LINE_WORDS,
    parameter logic [23:0] MMIO_TAG   = DEF_MMIO_TAG
) (
    input wire logic               clk,
    input wire logic               rstn,
    dcache_mmio_responder_if.slave bus
);

    localparam int c_OFF_W = $clog2(LINE_WORDS);
    localparam int c_IDX_W = $clog2(SETS);
    localparam int c_TAG_W = 32 - c_IDX_W - c_OFF_W - 2;
    localparam logic [c_OFF_W-1:0] c_LAST = c_OFF_W'(LINE_WORDS - 1);

    state_t               r_state;
    logic [c_OFF_W-1:0]   r_cnt;
    logic [31:0]          r_rdata_hold;

    logic [c_OFF_W-1:0]   w_offset;
    logic [c_OFF_W-1:0]   w_rd_offset;
    logic [c_OFF_W-1:0]   w_wr_offset;
    logic [c_IDX_W-1:0]   w_index;
    logic [c_TAG_W-1:0]   w_tag;
    logic [c_TAG_W-1:0]   w_rd_tag;
    logic [31:0]          w_rd_word;
    logic [31:0]          w_rd_live;
    logic [31:0]          w_wr_word;
    logic                 w_rd_valid;
    logic                 w_rd_dirty;
    logic                 w_req;
    logic                 w_store;
    logic                 w_mmio;
    logic                 w_hit;
    logic                 w_access;
    logic                 w_cache_store;
    logic                 w_fill_ack;
    logic                 w_last;
    logic                 w_word_we;
    logic                 w_line_fill;

    assign w_offset = c_OFF_W'(addr_offset(bus.addr, c_OFF_W));
    assign w_index  = c_IDX_W'(addr_index(bus.addr, c_OFF_W, c_IDX_W));
    assign w_tag    = c_TAG_W'(addr_tag(bus.addr, c_OFF_W, c_IDX_W));

    assign w_req   = bus.r_valid | bus.w_valid;
    assign w_store = bus.w_valid;     // store wins when both are raised
    assign w_mmio  = (bus.addr[31:8] == MMIO_TAG);
    assign w_hit   = w_rd_valid && (w_rd_tag == w_tag);
    assign w_last  = (r_cnt == c_LAST);

    // The access completes this cycle: an IDLE hit, the post-refill DONE
    // cycle, or the single IO cycle. Everything is masked while in reset.
    assign w_access = rstn && w_req &&
                      ((r_state == IDLE && !w_mmio && w_hit) ||
                       (r_state == DONE) || (r_state == IO));
    assign w_cache_store = w_access && w_store && (r_state != IO);
    assign w_fill_ack    = rstn && (r_state == FILL) && bus.mem_ack;
    assign w_word_we     = w_cache_store || w_fill_ack;
    assign w_line_fill   = w_fill_ack && w_last;

    // Write-back reads the victim word selected by the burst counter.
    assign w_rd_offset = (r_state == WBACK) ? r_cnt : w_offset;
    assign w_wr_offset = (r_state == FILL) ? r_cnt : w_offset;
    assign w_wr_word   = (r_state == FILL) ? bus.mem_rdata : bus.w_data;
    assign w_rd_live   = (r_state == IO) ? bus.io_din : w_rd_word;

    dcache_line_store #(
        .OFFSET_BITS (c_OFF_W),
        .INDEX_BITS  (c_IDX_W),
        .TAG_BITS    (c_TAG_W)
    ) u_line_store (
        .clk       (clk),
        .rstn      (rstn),
        .index     (w_index),
        .rd_offset (w_rd_offset),
        .rd_word   (w_rd_word),
        .rd_tag    (w_rd_tag),
        .rd_valid  (w_rd_valid),
        .rd_dirty  (w_rd_dirty),
        .word_we   (w_word_we),
        .wr_offset (w_wr_offset),
        .wr_word   (w_wr_word),
        .line_fill (w_line_fill),
        .wr_tag    (w_tag),
        .dirty_set (w_cache_store)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_rdata_hold <= '0;
        end else begin
            if (w_access && !w_store) begin
                r_rdata_hold <= w_rd_live;
            end
            unique case (r_state)
                IDLE: begin
                    if (w_req) begin
                        if (w_mmio) begin
                            r_state <= IO;
                        end else if (!w_hit) begin
                            r_cnt   <= '0;
                            r_state <= (w_rd_valid && w_rd_dirty) ? WBACK : FILL;
                        end
                    end
                end
                WBACK: begin
                    if (bus.mem_ack) begin
                        r_cnt <= r_cnt + c_OFF_W'(1);
                        if (w_last) begin
                            r_cnt   <= '0;
                            r_state <= FILL;
                        end
                    end
                end
                FILL: begin
                    if (bus.mem_ack) begin
                        r_cnt <= r_cnt + c_OFF_W'(1);
                        if (w_last) begin
                            r_state <= DONE;
                        end
                    end
                end
                DONE:    r_state <= IDLE;
                IO:      r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // Completion pulses are combinational so a hit costs no extra cycle;
    // r_data shows the live word while r_ready is high and the held copy
    // otherwise.
    assign bus.r_ready   = w_access && !w_store;
    assign bus.w_ready   = w_access && w_store;
    assign bus.r_data    = !rstn ? 32'd0 : (bus.r_ready ? w_rd_live : r_rdata_hold);

    assign bus.mem_req   = rstn && ((r_state == WBACK) || (r_state == FILL));
    assign bus.mem_we    = rstn && (r_state == WBACK);
    assign bus.mem_addr  = (r_state == WBACK) ? {w_rd_tag, w_index, r_cnt, 2'b00}
                                              : {w_tag, w_index, r_cnt, 2'b00};
    assign bus.mem_wdata = w_rd_word;

    assign bus.io_addr   = bus.addr[7:0];
    assign bus.io_dout   = bus.w_data;
    assign bus.io_we     = rstn && (r_state == IO) && w_req && bus.w_valid;
    assign bus.io_rd     = rstn && (r_state == IO) && w_req && !bus.w_valid;

endmodule
`default_nettype wire
